addsub_arbiter: RTL and testbench

Controller that shares one CLA add/sub datapath between two requesters, e.g. ALU issue and address generation. It arbitrates requests, latches the operands, and drives the adder for one cycle. It then captures the result and overflow into a response register held under a valid/ready handshake. It sits between the requesters and an externally instantiated CLA_ADD_SUB, whose ports it drives.

---
 rtl/addsub_arbiter.sv | 141 ++++++++++++++
 tb/tb_addsub_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// Two-requester front end for a shared CLA add/sub datapath: arbitrates, drives the adder
// for one cycle and holds the result under valid/ready. Define ADDSUB_ARB_RR_EN for round-robin.
module addsub_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_rs_1,
    input  logic [WIDTH-1:0] req0_rs_2,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_rs_1,
    input  logic [WIDTH-1:0] req1_rs_2,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             add_en,
    output logic [WIDTH-1:0] add_rs_1,
    output logic [WIDTH-1:0] add_rs_2,
    output logic             add_funct7_5,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   grant_valid_s;
    logic   grant_id_s;

`ifdef ADDSUB_ARB_RR_EN
    logic   last_grant_r;
`endif

    // Grant selection: a lone requester always wins; a tie is broken by the arbitration policy.
    always_comb begin
        grant_valid_s = req0_valid | req1_valid;
        grant_id_s    = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ADDSUB_ARB_RR_EN
            grant_id_s = ~last_grant_r;
`else
            grant_id_s = 1'b0;
`endif
        end else if (req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // Ready is combinational so the requester sees acceptance in the grant cycle itself.
    always_comb begin
        req0_ready = (state_r == IDLE) && grant_valid_s && !grant_id_s;
        req1_ready = (state_r == IDLE) && grant_valid_s && grant_id_s;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: state_next_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, operand and response registers; operands stay put outside a grant so the adder inputs never toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= {WIDTH{1'b0}};
            rsp_overflow <= 1'b0;
            add_en       <= 1'b0;
            add_rs_1     <= {WIDTH{1'b0}};
            add_rs_2     <= {WIDTH{1'b0}};
            add_funct7_5 <= 1'b0;
`ifdef ADDSUB_ARB_RR_EN
            last_grant_r <= 1'b1;
`endif
        end else begin
            state_r <= state_next_s;
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        add_rs_1     <= grant_id_s ? req1_rs_1 : req0_rs_1;
                        add_rs_2     <= grant_id_s ? req1_rs_2 : req0_rs_2;
                        add_funct7_5 <= grant_id_s ? req1_sub  : req0_sub;
                        rsp_id       <= grant_id_s;
                        add_en       <= 1'b1;
`ifdef ADDSUB_ARB_RR_EN
                        last_grant_r <= grant_id_s;
`endif
                    end
                end
                EXEC: begin
                    rsp_result   <= add_result;
                    rsp_overflow <= add_overflow;
                    rsp_valid    <= 1'b1;
                    add_en       <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    add_en    <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter with a behavioural model of the shared adder.
// Expected grant order follows ADDSUB_ARB_RR_EN when it is defined.
module tb_addsub_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_rs_1 = '0, req0_rs_2 = '0, req1_rs_1 = '0, req1_rs_2 = '0;
    logic             req0_sub = 1'b0, req1_sub = 1'b0;
    logic             rsp_valid, rsp_id, rsp_overflow;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_result;
    logic             add_en, add_funct7_5, add_overflow;
    logic [WIDTH-1:0] add_rs_1, add_rs_2, add_result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs_1(req0_rs_1),
        .req0_rs_2(req0_rs_2), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs_1(req1_rs_1),
        .req1_rs_2(req1_rs_2), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .add_en(add_en), .add_rs_1(add_rs_1), .add_rs_2(add_rs_2),
        .add_funct7_5(add_funct7_5), .add_result(add_result), .add_overflow(add_overflow)
    );

    // Stand-in for the external CLA_ADD_SUB.
    always_comb begin
        add_result   = add_funct7_5 ? (add_rs_1 - add_rs_2) : (add_rs_1 + add_rs_2);
        add_overflow = add_funct7_5
            ? ((add_rs_1[WIDTH-1] != add_rs_2[WIDTH-1]) && (add_result[WIDTH-1] != add_rs_1[WIDTH-1]))
            : ((add_rs_1[WIDTH-1] == add_rs_2[WIDTH-1]) && (add_result[WIDTH-1] != add_rs_1[WIDTH-1]));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_rsp_result"}, rsp_result, 32'd0);
        check({tag, "_rsp_ovf"}, 32'(rsp_overflow), 32'd0);
        check({tag, "_add_en"}, 32'(add_en), 32'd0);
        check({tag, "_add_rs_1"}, add_rs_1, 32'd0);
        check({tag, "_add_rs_2"}, add_rs_2, 32'd0);
        check({tag, "_funct"}, 32'(add_funct7_5), 32'd0);
    endtask

    // One operation from IDLE with the consumer always ready.
    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] exp_res, input logic exp_ovf);
        rsp_ready = 1'b1;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_rs_1 = a; req0_rs_2 = b; req0_sub = sub;
        end else begin
            req1_valid = 1'b1; req1_rs_1 = a; req1_rs_2 = b; req1_sub = sub;
        end
        #1;
        check("op_ready0", 32'(req0_ready), 32'(!id));
        check("op_ready1", 32'(req1_ready), 32'(id));
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("op_exec_en", 32'(add_en), 32'd1);
        check("op_exec_rs1", add_rs_1, a);
        check("op_exec_rs2", add_rs_2, b);
        check("op_exec_funct", 32'(add_funct7_5), 32'(sub));
        check("op_exec_nordy", 32'(req0_ready | req1_ready), 32'd0);
        tick();
        check("op_rsp_valid", 32'(rsp_valid), 32'd1);
        check("op_rsp_id", 32'(rsp_id), 32'(id));
        check("op_rsp_result", rsp_result, exp_res);
        check("op_rsp_ovf", 32'(rsp_overflow), 32'(exp_ovf));
        check("op_rsp_en", 32'(add_en), 32'd0);
        tick();
        check("op_done_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic exp_id;

        // Reset state
        do_reset();
        #1;
        check_all_zero("reset");
        check("reset_ready0", 32'(req0_ready), 32'd0);
        check("reset_ready1", 32'(req1_ready), 32'd0);

        // Basic arithmetic, including signed-overflow boundaries
        run_op(1'b0, 32'd5, 32'd3, 1'b0, 32'd8, 1'b0);
        run_op(1'b1, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0);
        run_op(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b1);
        run_op(1'b1, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b0);

        // Both requesters continuously valid after reset
        do_reset();
        req0_valid = 1'b1; req0_rs_1 = 32'd10; req0_rs_2 = 32'd1; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_rs_1 = 32'd20; req1_rs_2 = 32'd2; req1_sub = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
`ifdef ADDSUB_ARB_RR_EN
            exp_id = 1'(g % 2);
`else
            exp_id = 1'b0;
`endif
            check("arb_ready0", 32'(req0_ready), 32'(!exp_id));
            check("arb_ready1", 32'(req1_ready), 32'(exp_id));
            tick();
            check("arb_exec_en", 32'(add_en), 32'd1);
            tick();
            check("arb_rsp_id", 32'(rsp_id), 32'(exp_id));
            check("arb_rsp_result", rsp_result, exp_id ? 32'd18 : 32'd11);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Backpressure in RESP with a pending req1
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_rs_1 = 32'd1; req0_rs_2 = 32'd1; req0_sub = 1'b0;
        #1;
        check("bp_ready0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_rs_1 = 32'd3; req1_rs_2 = 32'd4; req1_sub = 1'b0;
        #1;
        check("bp_exec_ready1", 32'(req1_ready), 32'd0);
        tick();
        for (int c = 0; c < 4; c++) begin
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_result", rsp_result, 32'd2);
            check("bp_hold_id", 32'(rsp_id), 32'd0);
            check("bp_hold_ready1", 32'(req1_ready), 32'd0);
            check("bp_hold_ready0", 32'(req0_ready), 32'd0);
            check("bp_hold_en", 32'(add_en), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_hs_ready1", 32'(req1_ready), 32'd0);
        tick();
        check("bp_idle_valid", 32'(rsp_valid), 32'd0);
        check("bp_idle_ready1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check("bp_r1_en", 32'(add_en), 32'd1);
        tick();
        check("bp_r1_result", rsp_result, 32'd7);
        check("bp_r1_id", 32'(rsp_id), 32'd1);
        tick();

        // Reset during EXEC discards the operation
        req1_valid = 1'b1; req1_rs_1 = 32'd9; req1_rs_2 = 32'd9; req1_sub = 1'b1;
        #1;
        check("rx_ready1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check("rx_exec_en", 32'(add_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rx");
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rx_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req0_valid = 1'b1; req0_rs_1 = 32'd2; req0_rs_2 = 32'd2; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_rs_1 = 32'd6; req1_rs_2 = 32'd1; req1_sub = 1'b0;
        #1;
        check("rx_first_ready0", 32'(req0_ready), 32'd1);
        check("rx_first_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("rx_first_result", rsp_result, 32'd4);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
